// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl
//   Turns raw active-low pedestrian push-buttons (one per pole) into clean
//   per-pole crossing requests for the traffic signal controller. Each button
//   is synchronised and debounced, and its press edge is detected. The
//   resulting request is held until the controller acknowledges it. A
//   saturating BCD counter of accepted requests feeds the 7-segment decoder.
//   Runs on the fast system clock, ahead of the 1 Hz divider.
//
// Ports
//   clk        in   system clock (100 MHz)
//   rst        in   asynchronous reset, active low
//   btn_n      in   [NUM_BTN] raw buttons, 0 = pressed, asynchronous to clk
//   ack        in   [NUM_BTN] high while req[i]=1 means pole i was served
//   req        out  [NUM_BTN] pending crossing request per pole
//   btn_level  out  [NUM_BTN] debounced button state, 1 = pressed
//   req_cnt    out  [4]       accepted-request count, BCD 0..9, saturating
//
// Parameters
//   NUM_BTN (1..4), DB_CYCLES (>= 2) stable cycles to accept a new level,
//   LOCKOUT_CYCLES post-service lockout length.
//
// Build option
//   BTN_LOCKOUT_EN : when defined, a served pole returns to idle only after
//   the button is released AND LOCKOUT_CYCLES cycles have elapsed since
//   the ack. When undefined, release alone suffices and no lockout counter
//   exists.
`timescale 1ns/1ps
module ped_request_ctrl #(
  parameter int NUM_BTN        = 2,
  parameter int DB_CYCLES      = 2000000,
  parameter int LOCKOUT_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic [NUM_BTN-1:0] ack,
  output logic [NUM_BTN-1:0] req,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [3:0]         req_cnt
);

  localparam int             DBW     = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  if (NUM_BTN < 1 || NUM_BTN > 4 || DB_CYCLES < 2 || LOCKOUT_CYCLES < 1) begin : g_param_check
    $error("ped_request_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SERVED} state_t;

  logic [NUM_BTN-1:0] r_sync1, r_sync2;
  logic [NUM_BTN-1:0] r_level, r_level_d;
  logic [DBW-1:0]     r_db_cnt [NUM_BTN];
  state_t             r_state  [NUM_BTN];
  state_t             w_next   [NUM_BTN];
  logic [NUM_BTN-1:0] r_req;
  logic [3:0]         r_cnt;

  logic [NUM_BTN-1:0] w_samp, w_press, w_accept, w_ack_take, w_req_next, w_lock_done;
  logic [4:0]         w_cnt_sum;
  logic [3:0]         w_cnt_next;

  assign w_samp  = ~r_sync2;
  assign w_press = r_level & ~r_level_d;

  // Synchroniser and debounce: the level only moves after DB_CYCLES
  // consecutive samples disagree with it; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_level   <= '0;
      r_level_d <= '0;
      for (int i = 0; i < NUM_BTN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= btn_n;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_samp[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_level[i]  <= w_samp[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_LOCKOUT_EN
  localparam int LKW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LKW-1:0] r_lock [NUM_BTN];

  // Loaded on the ack edge, then counts down to zero and parks there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BTN; i++) r_lock[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_ack_take[i])          r_lock[i] <= LKW'(LOCKOUT_CYCLES);
        else if (r_lock[i] != '0)   r_lock[i] <= r_lock[i] - 1'b1;
      end
    end
  end

  always_comb begin
    w_lock_done = '0;
    for (int i = 0; i < NUM_BTN; i++) w_lock_done[i] = (r_lock[i] == '0);
  end
`else
  assign w_lock_done = '1;
`endif

  // Request FSM per pole. An ack in PEND wins over a coincident press; the
  // press is simply not looked at outside IDLE, so it is neither taken nor
  // counted.
  always_comb begin
    w_accept   = '0;
    w_ack_take = '0;
    w_req_next = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_next[i] = r_state[i];
      case (r_state[i])
        ST_IDLE: begin
          if (w_press[i]) begin
            w_next[i]   = ST_PEND;
            w_accept[i] = 1'b1;
          end
        end
        ST_PEND: begin
          if (ack[i]) begin
            w_next[i]     = ST_SERVED;
            w_ack_take[i] = 1'b1;
          end
        end
        ST_SERVED: begin
          if (!r_level[i] && w_lock_done[i]) w_next[i] = ST_IDLE;
        end
        default: w_next[i] = ST_IDLE;
      endcase
      w_req_next[i] = (w_next[i] == ST_PEND);
    end
  end

  // Several poles may be accepted on the same edge; add them all, clamp at 9.
  always_comb begin
    w_cnt_sum = {1'b0, r_cnt};
    for (int i = 0; i < NUM_BTN; i++) w_cnt_sum = w_cnt_sum + {4'd0, w_accept[i]};
    w_cnt_next = (w_cnt_sum > 5'd9) ? 4'd9 : w_cnt_sum[3:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BTN; i++) r_state[i] <= ST_IDLE;
      r_req <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) r_state[i] <= w_next[i];
      r_req <= w_req_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign req       = r_req;
  assign btn_level = r_level;
  assign req_cnt   = r_cnt;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Testbench for ped_request_ctrl (NUM_BTN=2, DB_CYCLES=4, LOCKOUT_CYCLES=10).
// A behavioural model tracks, per pole, how long the synchronised sample has
// disagreed with the debounced level, plus pending / waiting-for-release
// flags and an integer press count; its outputs are compared every cycle.
`timescale 1ns/1ps
module tb_ped_request_ctrl;
  localparam int NB = 2;
  localparam int DB = 4;
  localparam int LK = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_n = '1;
  logic [NB-1:0] ack = '0;
  logic [NB-1:0] req, btn_level;
  logic [3:0]    req_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ped_request_ctrl #(
    .NUM_BTN(NB), .DB_CYCLES(DB), .LOCKOUT_CYCLES(LK)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .ack(ack),
    .req(req), .btn_level(btn_level), .req_cnt(req_cnt)
  );

  // Behavioural model
  logic [NB-1:0] m_d1, m_d2, m_lvl, m_lvl_d, m_pend, m_wait;
  int m_run [NB];
  int m_lock[NB];
  int m_cnt;

  always @(posedge clk or negedge rst) begin : model
    logic [NB-1:0] old_lvl, old_lvl_d, samp;
    int  acc;
    bit  lock_done;
    if (!rst) begin
      m_d1 = '1; m_d2 = '1; m_lvl = '0; m_lvl_d = '0;
      m_pend = '0; m_wait = '0; m_cnt = 0;
      for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_lock[i] = 0; end
    end else begin
      old_lvl   = m_lvl;
      old_lvl_d = m_lvl_d;
      samp      = ~m_d2;
      m_d2      = m_d1;
      m_d1      = btn_n;
      m_lvl_d   = old_lvl;
      acc       = 0;
      for (int i = 0; i < NB; i++) begin
        if (samp[i] != old_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin m_lvl[i] = samp[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
        lock_done = (m_lock[i] == 0);
        if (m_lock[i] > 0) m_lock[i] = m_lock[i] - 1;
        if (m_pend[i]) begin
          if (ack[i]) begin
            m_pend[i] = 1'b0;
            m_wait[i] = 1'b1;
`ifdef BTN_LOCKOUT_EN
            m_lock[i] = LK;
`endif
          end
        end else if (m_wait[i]) begin
          if (!old_lvl[i] && lock_done) m_wait[i] = 1'b0;
        end else if (old_lvl[i] && !old_lvl_d[i]) begin
          m_pend[i] = 1'b1;
          acc = acc + 1;
        end
      end
      m_cnt = (m_cnt + acc > 9) ? 9 : m_cnt + acc;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (req !== m_pend || btn_level !== m_lvl || req_cnt !== 4'(m_cnt)) begin
        errors++;
        $display("FAIL model_cmp t=%0t req=%b exp=%b btn_level=%b exp=%b req_cnt=%0d exp=%0d",
                 $time, req, m_pend, btn_level, m_lvl, req_cnt, m_cnt);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic bounce [5];
    int   exp_cnt;
    bounce = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    #1 rst = 1'b0;
    cmp_en = 1'b1;
    step(3);
    rst = 1'b1;

    // Idle buttons
    step(20);
    chk("idle_req", 8'(req), 8'd0);
    chk("idle_lvl", 8'(btn_level), 8'd0);
    chk("idle_cnt", 8'(req_cnt), 8'd0);

    // Clean press: level after 2+DB edges, request one edge later
    btn_n[0] = 1'b0;
    step(5);
    chk("lvl_early", 8'(btn_level[0]), 8'd0);
    step(1);
    chk("lvl_at_6", 8'(btn_level[0]), 8'd1);
    chk("req_not_yet", 8'(req[0]), 8'd0);
    step(1);
    chk("req_at_7", 8'(req[0]), 8'd1);
    chk("cnt_first", 8'(req_cnt), 8'd1);

    // Ack, hold button: no re-request
    ack[0] = 1'b1;
    step(1);
    ack[0] = 1'b0;
    chk("req_acked", 8'(req[0]), 8'd0);
    step(50);
    chk("held_no_req", 8'(req[0]), 8'd0);
    chk("held_cnt", 8'(req_cnt), 8'd1);
    btn_n[0] = 1'b1;
    step(10);
    btn_n[0] = 1'b0;
    step(7);
    chk("repress_req", 8'(req[0]), 8'd1);
    chk("repress_cnt", 8'(req_cnt), 8'd2);
    ack[0] = 1'b1;
    step(1);
    ack[0] = 1'b0;
    btn_n[0] = 1'b1;
    step(12);

    // Bounce shorter than the debounce window
    for (int k = 0; k < 5; k++) begin
      btn_n[1] = bounce[k];
      step(1);
    end
    btn_n[1] = 1'b1;
    step(10);
    chk("bounce_lvl", 8'(btn_level[1]), 8'd0);
    chk("bounce_req", 8'(req[1]), 8'd0);
    chk("bounce_cnt", 8'(req_cnt), 8'd2);

    // Simultaneous presses add together
    btn_n = '0;
    step(7);
    chk("both_req", 8'(req), 8'd3);
    chk("both_cnt", 8'(req_cnt), 8'd4);
    ack = '1;
    step(1);
    ack = '0;
    btn_n = '1;
    step(12);
    chk("both_served", 8'(req), 8'd0);

    // Release while pending, then ack together with a fresh press
    btn_n[0] = 1'b0;
    step(7);
    chk("lk_req", 8'(req[0]), 8'd1);
    btn_n[0] = 1'b1;
    step(8);
    chk("lk_released_pend", 8'(req[0]), 8'd1);
    ack[0]   = 1'b1;
    btn_n[0] = 1'b0;
    step(1);
    ack[0] = 1'b0;
    step(10);
`ifdef BTN_LOCKOUT_EN
    chk("press_in_lockout", 8'(req[0]), 8'd0);
    chk("lockout_cnt", 8'(req_cnt), 8'd5);
`else
    chk("press_after_serve", 8'(req[0]), 8'd1);
    chk("after_serve_cnt", 8'(req_cnt), 8'd6);
`endif
    btn_n[0] = 1'b1;
    step(12);
    btn_n[0] = 1'b0;
    step(7);
    chk("post_lock_req", 8'(req[0]), 8'd1);
    chk("post_lock_cnt", 8'(req_cnt), 8'd6);
    ack[0] = 1'b1;
    step(1);
    ack[0] = 1'b0;
    btn_n[0] = 1'b1;
    step(12);

    // Saturation at 9
    exp_cnt = 6;
    for (int k = 0; k < 12; k++) begin
      btn_n[0] = 1'b0;
      step(7);
      exp_cnt = (exp_cnt < 9) ? exp_cnt + 1 : 9;
      chk("sat_cnt", 8'(req_cnt), 8'(exp_cnt));
      ack[0] = 1'b1;
      step(1);
      ack[0] = 1'b0;
      btn_n[0] = 1'b1;
      step(12);
    end
    chk("sat_final", 8'(req_cnt), 8'd9);

    // Asynchronous reset mid-request
    btn_n[1] = 1'b0;
    step(7);
    chk("pre_rst_req", 8'(req[1]), 8'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_req", 8'(req), 8'd0);
    chk("async_rst_cnt", 8'(req_cnt), 8'd0);
    chk("async_rst_lvl", 8'(btn_level), 8'd0);
    btn_n = '1;
    step(2);
    rst = 1'b1;
    step(5);

    // Randomised run
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 9) == 0) btn_n[i] = ~btn_n[i];
        ack[i] = ($urandom_range(0, 3) == 0);
      end
      step(1);
    end
    ack = '0;
    btn_n = '1;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
